// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared widths, register count and data-word type for register_file
package register_file_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_REGS_DEF   = 2 ** ADDR_WIDTH_DEF;

  typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - combinational read mux; address 0 always returns zero
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                    addr,
  output logic [DATA_WIDTH-1:0]                    data
);

  always_comb begin
    data = regs[addr];
    if (addr == '0) begin
      data = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 2**ADDR_WIDTH x DATA_WIDTH register file, one write port, two combinational read ports
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ReadAddress1,
  input  logic [ADDR_WIDTH-1:0] ReadAddress2,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  ReadWriteEn,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (ReadWriteEn && (WriteAddress != '0)) begin
      regs[WriteAddress] <= WriteData;
    end
  end

  rf_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_read_port1 (
    .regs(regs),
    .addr(ReadAddress1),
    .data(ReadData1)
  );

  rf_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_read_port2 (
    .regs(regs),
    .addr(ReadAddress2),
    .data(ReadData2)
  );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  ReadAddress1;
  logic [4:0]  ReadAddress2;
  logic [4:0]  WriteAddress;
  logic [31:0] WriteData;
  logic        ReadWriteEn;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int tests_run;
  int tests_failed;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ReadAddress1(ReadAddress1),
    .ReadAddress2(ReadAddress2),
    .WriteAddress(WriteAddress),
    .WriteData(WriteData),
    .ReadWriteEn(ReadWriteEn),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    ReadWriteEn  = 1'b1;
    WriteAddress = a;
    WriteData    = d;
    @(posedge clk);
    #1;
    ReadWriteEn = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2);
    ReadAddress1 = a1;
    ReadAddress2 = a2;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    ReadAddress1 = 5'd0;
    ReadAddress2 = 5'd0;
    WriteAddress = 5'd0;
    WriteData    = 32'd0;
    ReadWriteEn  = 1'b0;

    @(posedge clk);
    #1;
    read_pair(5'd8, 5'd31);
    check("reset_r8", ReadData1, 32'd0);
    check("reset_r31", ReadData2, 32'd0);
    rst = 1'b0;

    // Basic writes and dual reads
    write_reg(5'd8, 32'd294);
    write_reg(5'd13, 32'd194);
    read_pair(5'd8, 5'd13);
    check("r8", ReadData1, 32'd294);
    check("r13", ReadData2, 32'd194);

    write_reg(5'd3, 32'd48);
    write_reg(5'd10, 32'd123);
    read_pair(5'd3, 5'd10);
    check("r3", ReadData1, 32'd48);
    check("r10", ReadData2, 32'd123);
    read_pair(5'd8, 5'd13);
    check("r8_kept", ReadData1, 32'd294);
    check("r13_kept", ReadData2, 32'd194);
    read_pair(5'd10, 5'd10);
    check("same_addr_p1", ReadData1, 32'd123);
    check("same_addr_p2", ReadData2, 32'd123);

    // Register 0 stays zero
    write_reg(5'd0, 32'hFFFF_FFFF);
    read_pair(5'd0, 5'd0);
    check("r0_p1", ReadData1, 32'd0);
    check("r0_p2", ReadData2, 32'd0);

    // Disabled write over several edges
    ReadWriteEn  = 1'b0;
    WriteAddress = 5'd5;
    WriteData    = 32'd77;
    repeat (3) @(posedge clk);
    #1;
    read_pair(5'd5, 5'd8);
    check("r5_no_write", ReadData1, 32'd0);
    check("r8_no_write", ReadData2, 32'd294);

    // Same-cycle read of the written register: old value, then new
    write_reg(5'd7, 32'd11);
    read_pair(5'd7, 5'd3);
    ReadWriteEn  = 1'b1;
    WriteAddress = 5'd7;
    WriteData    = 32'd55;
    #1;
    check("r7_before_edge", ReadData1, 32'd11);
    @(posedge clk);
    #1;
    ReadWriteEn = 1'b0;
    check("r7_after_edge", ReadData1, 32'd55);

    // Fill r1..r31, then reset between edges
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i * 3 + 1));
    end
    read_pair(5'd1, 5'd31);
    check("fill_r1", ReadData1, 32'd4);
    check("fill_r31", ReadData2, 32'd94);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      read_pair(5'(i), 5'(31 - i));
      check("async_reset_p1", ReadData1, 32'd0);
      check("async_reset_p2", ReadData2, 32'd0);
    end

    // Writes blocked while reset is held
    ReadWriteEn  = 1'b1;
    WriteAddress = 5'd4;
    WriteData    = 32'd9;
    @(posedge clk);
    #1;
    ReadWriteEn = 1'b0;
    read_pair(5'd4, 5'd4);
    check("write_blocked_rst", ReadData1, 32'd0);
    rst = 1'b0;
    #1;
    check("write_blocked_after", ReadData2, 32'd0);

    // First write after reset release
    write_reg(5'd4, 32'd9);
    read_pair(5'd4, 5'd7);
    check("first_write_after_rst", ReadData1, 32'd9);
    check("r7_cleared", ReadData2, 32'd0);

    // Reset asserted during a write cycle wins
    ReadWriteEn  = 1'b1;
    WriteAddress = 5'd12;
    WriteData    = 32'd600;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    ReadWriteEn = 1'b0;
    rst         = 1'b0;
    read_pair(5'd12, 5'd4);
    check("rst_wins_r12", ReadData1, 32'd0);
    check("rst_wins_r4", ReadData2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every register and data port.
REQ-002 Parameter ADDR_WIDTH, default 5: address width; register count = 2**ADDR_WIDTH (32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ReadAddress1  input  ADDR_WIDTH  register index for read port 1.
REQ-006 ReadAddress2  input  ADDR_WIDTH  register index for read port 2.
REQ-007 WriteAddress  input  ADDR_WIDTH  register index for the write port.
REQ-008 WriteData  input  DATA_WIDTH  value to store.
REQ-009 ReadWriteEn  input  1  1 = write enabled this cycle; 0 = read-only cycle.
REQ-010 ReadData1  output  DATA_WIDTH  contents of register ReadAddress1.
REQ-011 ReadData2  output  DATA_WIDTH  contents of register ReadAddress2.

Function
REQ-012 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits.
REQ-013 On rising clk with ReadWriteEn=1 and rst=0, register[WriteAddress] SHALL take WriteData; at most one register written per cycle.
REQ-014 With ReadWriteEn=0, no register SHALL change.
REQ-015 Reads SHALL be combinational (zero latency): ReadData1/2 follow address changes and register contents within the same cycle, without waiting for a clock edge.
REQ-016 Both read ports SHALL be independent; identical addresses on both ports return identical data.
REQ-017 Register 0 SHALL be hardwired to zero: writes to address 0 are ignored and reads of address 0 return 0.
REQ-018 Read of the address being written in the same cycle SHALL return the old value before the edge and the new value immediately after it; no write-to-read bypass.
REQ-019 All read ports and the write port SHALL accept every address 0..2**ADDR_WIDTH-1; no out-of-range condition exists.
REQ-020 WriteData and WriteAddress SHALL be ignored when ReadWriteEn=0.

Reset
REQ-021 Asserting rst SHALL immediately (asynchronously) clear every register to 0; ReadData1/2 then read 0 for all addresses.
REQ-022 While rst=1, writes SHALL be blocked regardless of ReadWriteEn.
REQ-023 After rst deasserts, the first rising clk with ReadWriteEn=1 SHALL perform a normal write.
REQ-024 rst asserted in the middle of a write cycle SHALL win: the register ends at 0.

Structure
REQ-025 Shared package SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, the register-count constant and a data-word typedef.
REQ-026 One sub-module, rf_read_port (combinational address-to-data mux including the register-0 zero rule), SHALL be instantiated twice; write logic and storage stay in register_file.

Verification
REQ-027 Reset then write r8=294, next cycle r13=194, ReadWriteEn=0, read r8/r13 -> ReadData1=294, ReadData2=194.
REQ-028 Continue: write r3=48, r10=123, read r3/r10 -> 48/123; r8/r13 still 294/194.
REQ-029 Write r0=0xFFFFFFFF, read r0 on both ports -> 0.
REQ-030 ReadWriteEn=0 with WriteAddress=5, WriteData=77 over several edges -> r5 reads 0.
REQ-031 Read r7 on port 1 while writing r7=55: ReadData1 = old value before edge, 55 after edge.
REQ-032 Load r1..r31 with non-zero values, assert rst between clock edges -> all reads 0 immediately, before next edge.
